// File: rtl/event_encoder8.sv
// event_encoder8: collects 8 event strobes into a pending vector and offers
// them one at a time as a binary code with a valid/ack handshake. Selection
// is round-robin starting just past the last served event.
module event_encoder8 (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pend,
  output logic [3:0] cnt,
  output logic       ovf
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state;
  logic [2:0] ptr;

  logic       xfer;
  logic [7:0] clr_mask;
  logic [7:0] p_nxt;
  logic [7:0] cand;
  logic       ovf_hit;
  logic [2:0] ptr_nxt;

  // first set bit of v searching p, p+1, ... wrapping 7->0
  function automatic logic [2:0] rr_sel(input logic [7:0] v, input logic [2:0] p);
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!found && v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int k = 0; k < 8; k++) s = s + {3'd0, v[k]};
    return s;
  endfunction

  // next pending vector: served bit drops only on a transfer, new strobes
  // always land (a strobe on the served bit re-arms it)
  always_comb begin
    xfer     = valid & ack;
    clr_mask = xfer ? (8'd1 << code) : 8'd0;
    p_nxt    = (pend & ~clr_mask) | req;
    cand     = pend & ~(8'd1 << code);
    ovf_hit  = |(req & pend & ~clr_mask);
    ptr_nxt  = code + 3'd1;
  end

  // offer FSM plus pending/count/overflow registers
  always_ff @(posedge clk) begin
    if (clr) begin
      pend  <= 8'd0;
      cnt   <= 4'd0;
      ovf   <= 1'b0;
      ptr   <= 3'd0;
      code  <= 3'd0;
      valid <= 1'b0;
      state <= IDLE;
    end else begin
      pend <= p_nxt;
      cnt  <= popcnt(p_nxt);
      if (ovf_hit) ovf <= 1'b1;
      case (state)
        IDLE: begin
          // selection sees only events already pending before this edge
          if (|pend) begin
            code  <= rr_sel(pend, ptr);
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            ptr <= ptr_nxt;
            if (|cand) begin
              code <= rr_sel(cand, ptr_nxt);
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
